multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/core_pkg.sv | 38 +++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/multicycle_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared states, opcodes, fault codes and NOP for the multicycle sequencer
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Opcodes whose ALU operand B is the immediate rather than rs2.
    function automatic logic uses_imm(input logic [6:0] op);
        return (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter for memory handshakes
// Ports: clk, rst_n (async active-low); clear restarts the count, tick advances
// it by one; expired is high during the TIMEOUT-th cycle since the last clear.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != LAST)) begin
            // Saturates so a stalled consumer never sees the count wrap.
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle fetch/decode/exec/mem/wb control sequencer
// Optional feature macro: INSTRET_COUNTER_EN adds the 64-bit instret output.
// Ports: clk, reset (async active-low); imem_* fetch handshake; instr = IR;
// branch_taken/target from the datapath; dmem_* data handshake; alu_src,
// mem_reg, jump_sel, reg_write datapath controls; pc_out/pc_plus4; retired
// pulse; halted and fault status.
module multicycle_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] target,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            alu_src,
    output logic            mem_reg,
    output logic            jump_sel,
    output logic            reg_write,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            retired,
    output logic            halted,
    output logic [1:0]      fault
`ifdef INSTRET_COUNTER_EN
    ,
    output logic [63:0]     instret
`endif
);

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [31:0]     instr_q;
    logic [31:0]     instr_d;
    logic [1:0]      fault_q;
    logic [1:0]      fault_d;

    logic [6:0] opcode;
    logic       is_load;
    logic       is_store;
    logic       is_jump;
    logic       target_misaligned;
    logic       wait_clear;
    logic       wait_tick;
    logic       wait_expired;

    assign opcode            = instr_q[6:0];
    assign is_load           = (opcode == OP_LOAD);
    assign is_store          = (opcode == OP_STORE);
    assign is_jump           = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign target_misaligned = (target[1:0] != 2'b00);

    assign pc_out    = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + XLEN'(4);
    assign instr     = instr_q;
    assign fault     = fault_q;
    assign halted    = (state_q == ST_HALT);

    // Any state change restarts the count, which covers every entry into
    // FETCH or MEM; only those two states ever advance it.
    assign wait_clear = (state_d != state_q);
    assign wait_tick  = (state_q == ST_FETCH) || (state_q == ST_MEM);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (wait_clear),
        .tick    (wait_tick),
        .expired (wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        fault_d   = fault_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src   = 1'b0;
        mem_reg   = 1'b0;
        jump_sel  = 1'b0;
        reg_write = 1'b0;
        retired   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                // Ready wins over expiry so a response on the last allowed
                // cycle is still taken.
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end
            end

            ST_DECODE: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                alu_src = uses_imm(opcode);
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        state_d = ST_MEM;
                    end
                    OP_REG, OP_IMM, OP_LUI, OP_AUIPC: begin
                        state_d = ST_WB;
                    end
                    OP_JAL, OP_JALR: begin
                        // Alignment is checked here so a bad jump never
                        // reaches write-back.
                        if (target_misaligned) begin
                            fault_d = FAULT_MISALIGN;
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                    OP_BRANCH: begin
                        if (branch_taken && target_misaligned) begin
                            fault_d = FAULT_MISALIGN;
                            state_d = ST_HALT;
                        end else begin
                            pc_d    = branch_taken ? target : pc_plus4;
                            retired = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                    OP_SYSTEM: begin
                        fault_d = FAULT_NONE;
                        state_d = ST_HALT;
                    end
                    default: begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = ST_HALT;
                    end
                endcase
            end

            ST_MEM: begin
                alu_src  = uses_imm(opcode);
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_d    = pc_plus4;
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = ST_HALT;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                mem_reg   = is_load;
                jump_sel  = is_jump;
                retired   = 1'b1;
                pc_d      = is_jump ? target : pc_plus4;
                state_d   = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

`ifdef INSTRET_COUNTER_EN
    logic [63:0] instret_q;
    logic [63:0] instret_d;

    assign instret_d = instret_q + {63'd0, retired};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer
module tb_multicycle_sequencer;
    import core_pkg::*;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_LW   = 32'h0000_2083;
    localparam logic [31:0] I_SW   = 32'h0010_2023;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_8067;
    localparam logic [31:0] I_ILL  = 32'hFFFF_FFFF;
    localparam logic [31:0] I_ECAL = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        branch_taken;
    logic [31:0] target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        alu_src;
    logic        mem_reg;
    logic        jump_sel;
    logic        reg_write;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        retired;
    logic        halted;
    logic [1:0]  fault;
`ifdef INSTRET_COUNTER_EN
    logic [63:0] instret;
`endif

    multicycle_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .branch_taken (branch_taken),
        .target       (target),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .alu_src      (alu_src),
        .mem_reg      (mem_reg),
        .jump_sel     (jump_sel),
        .reg_write    (reg_write),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .retired      (retired),
        .halted       (halted),
        .fault        (fault)
`ifdef INSTRET_COUNTER_EN
        ,
        .instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_halt;
        int          cyc;
        logic        rw;
        logic        mr;
        logic        js;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [1:0]  flt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          pend_pc = 0;
    logic [31:0] pend_val = '0;
    bit          halt_seen = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void exp_retire(input int c, input logic rw, input logic mr, input logic js,
                                       input logic [31:0] ir, input logic [31:0] pc_after);
        exp_t x;
        x.is_halt = 0; x.cyc = c; x.rw = rw; x.mr = mr; x.js = js;
        x.ir = ir; x.pc = pc_after; x.flt = 2'd0;
        sb.push_back(x);
    endfunction

    function automatic void exp_halt(input int c, input logic [1:0] f, input logic [31:0] pc);
        exp_t x;
        x.is_halt = 1; x.cyc = c; x.rw = 0; x.mr = 0; x.js = 0;
        x.ir = '0; x.pc = pc; x.flt = f;
        sb.push_back(x);
    endfunction

    // Monitor: cycle 0 is the IDLE cycle right after reset release.
    always @(negedge clk) begin
        if (!reset) begin
            cyc = 0;
            pend_pc = 0;
            halt_seen = 0;
        end else begin
            if (pend_pc) begin
                chk("pc_after_retire", 64'(pc_out), 64'(pend_val));
                pend_pc = 0;
            end
            if (reg_write) chk("reg_write_with_retired", 64'(retired), 64'd1);
            if (retired) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_retire: got retire at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("retire_kind", 64'(e.is_halt), 64'd0);
                    chk("retire_cycle", 64'(cyc), 64'(e.cyc));
                    chk("retire_reg_write", 64'(reg_write), 64'(e.rw));
                    chk("retire_mem_reg", 64'(mem_reg), 64'(e.mr));
                    chk("retire_jump_sel", 64'(jump_sel), 64'(e.js));
                    chk("retire_ir", 64'(instr), 64'(e.ir));
                    pend_pc = 1;
                    pend_val = e.pc;
                end
            end
            if (halted && !halt_seen) begin
                halt_seen = 1;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_halt: got halt at cycle %0d fault %0d expected none", cyc, fault);
                end else begin
                    e = sb.pop_front();
                    chk("halt_kind", 64'(e.is_halt), 64'd1);
                    chk("halt_cycle", 64'(cyc), 64'(e.cyc));
                    chk("halt_fault", 64'(fault), 64'(e.flt));
                    chk("halt_pc", 64'(pc_out), 64'(e.pc));
                    chk("halt_strobes", 64'({imem_req, dmem_req, dmem_we, reg_write, retired}), 64'd0);
                end
            end
            cyc++;
        end
    end

    task automatic start_run();
        reset = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;
        dmem_ready = 1'b0; branch_taken = 1'b0; target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", 64'(pc_out), 64'd0);
        chk("rst_ir", 64'(instr), 64'(NOP));
        chk("rst_halted_fault", 64'({halted, fault}), 64'd0);
        chk("rst_strobes", 64'({imem_req, dmem_req, dmem_we, reg_write, retired,
                                alu_src, mem_reg, jump_sel}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic serve_fetch(input logic [31:0] w, input int waits);
        int n = 0;
        while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
        chk("fetch_req_seen", 64'(imem_req), 64'd1);
        repeat (waits) begin @(posedge clk); #1; end
        imem_ready = 1'b1; imem_rdata = w;
        @(posedge clk); #1;
        imem_ready = 1'b0; imem_rdata = '0;
    endtask

    task automatic wait_mem(input logic we_exp);
        int n = 0;
        while (!dmem_req && n < 50) begin @(posedge clk); #1; n++; end
        chk("mem_req_seen", 64'(dmem_req), 64'd1);
        chk("mem_we", 64'(dmem_we), 64'(we_exp));
        chk("mem_alu_src", 64'(alu_src), 64'd1);
    endtask

    task automatic serve_mem(input int waits, input logic we_exp);
        wait_mem(we_exp);
        repeat (waits) begin @(posedge clk); #1; end
        dmem_ready = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || pend_pc) && n < 200) begin @(posedge clk); #1; n++; end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_held(input logic [1:0] f);
        repeat (3) @(posedge clk);
        #1;
        chk("held_halted", 64'(halted), 64'd1);
        chk("held_fault", 64'(fault), 64'(f));
        chk("held_strobes", 64'({imem_req, dmem_req, reg_write, retired}), 64'd0);
    endtask

    initial begin
        // addi, two fetch wait cycles, then the next fetch at PC 4 times out
        start_run();
        exp_retire(6, 1, 0, 0, I_ADDI, 32'h4);
        exp_halt(22, FAULT_TIMEOUT, 32'h4);
        serve_fetch(I_ADDI, 2);
        drain();
        check_held(FAULT_TIMEOUT);

        // fetch ready on the last allowed cycle is accepted
        start_run();
        exp_retire(18, 1, 0, 0, I_ADDI, 32'h4);
        serve_fetch(I_ADDI, 14);
        @(posedge clk); #1;
        chk("exec_alu_src_addi", 64'(alu_src), 64'd1);
        drain();

        // register-register op uses rs2
        start_run();
        exp_retire(4, 1, 0, 0, I_ADD, 32'h4);
        serve_fetch(I_ADD, 0);
        @(posedge clk); #1;
        chk("exec_alu_src_add", 64'(alu_src), 64'd0);
        drain();

        // beq taken, aligned target
        start_run();
        branch_taken = 1'b1; target = 32'h40;
        exp_retire(3, 0, 0, 0, I_BEQ, 32'h40);
        serve_fetch(I_BEQ, 0);
        drain();

        // beq not taken
        start_run();
        target = 32'h40;
        exp_retire(3, 0, 0, 0, I_BEQ, 32'h4);
        serve_fetch(I_BEQ, 0);
        drain();

        // beq taken, misaligned target
        start_run();
        branch_taken = 1'b1; target = 32'h42;
        exp_halt(4, FAULT_MISALIGN, 32'h0);
        serve_fetch(I_BEQ, 0);
        drain();
        check_held(FAULT_MISALIGN);

        // load with no data-memory response
        start_run();
        exp_halt(19, FAULT_TIMEOUT, 32'h0);
        serve_fetch(I_LW, 0);
        wait_mem(1'b0);
        drain();
        check_held(FAULT_TIMEOUT);

        // load completing immediately
        start_run();
        exp_retire(5, 1, 1, 0, I_LW, 32'h4);
        serve_fetch(I_LW, 0);
        serve_mem(0, 1'b0);
        drain();

        // store completing after one wait cycle
        start_run();
        exp_retire(5, 0, 0, 0, I_SW, 32'h4);
        serve_fetch(I_SW, 0);
        serve_mem(1, 1'b1);
        drain();

        // jal; stray imem/dmem ready outside their states must be ignored
        start_run();
        target = 32'h100;
        exp_retire(4, 1, 0, 1, I_JAL, 32'h100);
        serve_fetch(I_JAL, 0);
        imem_ready = 1'b1; imem_rdata = I_ILL; dmem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
        drain();

        // jalr to a misaligned target
        start_run();
        target = 32'h102;
        exp_halt(4, FAULT_MISALIGN, 32'h0);
        serve_fetch(I_JALR, 0);
        drain();

        // illegal opcode, then ecall
        start_run();
        exp_halt(4, FAULT_ILLEGAL, 32'h0);
        serve_fetch(I_ILL, 0);
        drain();
        check_held(FAULT_ILLEGAL);

        start_run();
        exp_halt(4, FAULT_NONE, 32'h0);
        serve_fetch(I_ECAL, 0);
        drain();

        // reset pulsed in the middle of a load at PC 4
        start_run();
        exp_retire(4, 1, 0, 0, I_ADDI, 32'h4);
        serve_fetch(I_ADDI, 0);
        serve_fetch(I_LW, 0);
        wait_mem(1'b0);
        chk("pre_reset_pc", 64'(pc_out), 64'h4);
        chk("pre_reset_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_reset_dmem_req", 64'(dmem_req), 64'd0);
        chk("mid_reset_pc", 64'(pc_out), 64'h0);
        chk("mid_reset_ir", 64'(instr), 64'(NOP));
        @(posedge clk); #1;
        reset = 1'b1;
        begin
            int n = 0;
            while (!imem_req && n < 20) begin @(posedge clk); #1; n++; end
        end
        chk("post_reset_fetch_req", 64'(imem_req), 64'd1);
        chk("post_reset_fetch_addr", 64'(imem_addr), 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
